data_mem_arbiter: RTL and testbench

Global data memory for the GPU, on the memory side of the per-thread data channels that the data controller drives. It accepts independent load and store requests on NUM_CHAN valid/ready channels and arbitrates them onto a single-port storage array at one access per cycle. It returns load data with a fixed latency and holds it until the channel consumes it. It also acknowledges each store with a one-cycle pulse.

---
 rtl/data_mem_arbiter_pkg.sv | 24 ++
 rtl/data_mem_arbiter_if.sv | 38 +++
 rtl/data_mem_arbiter_rr_arbiter.sv | 60 ++++++
 rtl/data_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the GPU global data memory: channel FSM states, request kinds, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_mem_pkg;

    localparam int DEF_NUM_CHAN     = 4;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PEND = 3'd1,
        INFL = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } chan_state_t;

    typedef enum logic {
        KIND_LOAD  = 1'b0,
        KIND_STORE = 1'b1
    } req_kind_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Per-channel load/store request and response bundle between the data controller and the data memory.
// Latency: n/a (wires only).
// Backpressure: valid/ready on load and store requests, load response held until resp_rdy.
// Modports: master = channel side (issues requests), slave = memory side (data_mem_arbiter).
interface data_mem_arbiter_if
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CHAN   = DEF_NUM_CHAN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_CHAN-1:0]                 mem2read_req_rdy;
    logic [NUM_CHAN-1:0][ADDR_WIDTH-1:0] mem2read_req_addr;
    logic [NUM_CHAN-1:0]                 mem2read_req_addr_val;
    logic [NUM_CHAN-1:0]                 mem2read_resp_rdy;
    logic [NUM_CHAN-1:0][DATA_WIDTH-1:0] mem2read_resp_data;
    logic [NUM_CHAN-1:0]                 mem2read_resp_data_val;
    logic [NUM_CHAN-1:0]                 mem2write_req_rdy;
    logic [NUM_CHAN-1:0][ADDR_WIDTH-1:0] mem2write_req_addr;
    logic [NUM_CHAN-1:0][DATA_WIDTH-1:0] mem2write_req_data;
    logic [NUM_CHAN-1:0]                 mem2write_req_val;
    logic [NUM_CHAN-1:0]                 mem2write_resp_val;

    modport master (
        input  mem2read_req_rdy, mem2read_resp_data, mem2read_resp_data_val,
               mem2write_req_rdy, mem2write_resp_val,
        output mem2read_req_addr, mem2read_req_addr_val, mem2read_resp_rdy,
               mem2write_req_addr, mem2write_req_data, mem2write_req_val
    );

    modport slave (
        output mem2read_req_rdy, mem2read_resp_data, mem2read_resp_data_val,
               mem2write_req_rdy, mem2write_resp_val,
        input  mem2read_req_addr, mem2read_req_addr_val, mem2read_resp_rdy,
               mem2write_req_addr, mem2write_req_data, mem2write_req_val
    );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Single-grant arbiter over the channels waiting for the storage array.
// Latency: combinational grant; pointer updates on the grant edge.
// Backpressure: none, one request granted every cycle any request is present.
// Ports: clk, reset (async active-low), req in, one-hot gnt and gnt_vld out.
// DATA_MEM_RR_ARB_EN defined: round-robin from an internal pointer; undefined: lowest index wins.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_vld
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    assign gnt_vld = |req;

`ifdef DATA_MEM_RR_ARB_EN
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the request nearest the pointer is the last writer.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = PW'((int'(ptr_q) + off) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) ptr_q <= PW'((i + 1) % N);
            end
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// GPU global data memory: per-channel load/store FSMs arbitrated onto one single-port array.
// Latency: store ack 2 cycles after handshake; load data READ_LATENCY+1 cycles after handshake.
// Backpressure: one request per channel in flight; load data held until resp_rdy is sampled high.
// Ports: clk, reset (async active-low), bus (data_mem_arbiter_if.slave, per-channel load/store).
// Grant policy: DATA_MEM_RR_ARB_EN selects round-robin, otherwise fixed priority (see rr_arbiter).
module data_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CHAN     = DEF_NUM_CHAN,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    chan_state_t           state_q [NUM_CHAN];
    chan_state_t           state_d [NUM_CHAN];
    req_kind_t             kind_q  [NUM_CHAN];
    logic [ADDR_WIDTH-1:0] addr_q  [NUM_CHAN];
    logic [DATA_WIDTH-1:0] wdat_q  [NUM_CHAN];
    logic [DATA_WIDTH-1:0] rdat_q  [NUM_CHAN];
    logic                  run_q;   // keeps every rdy low until the first edge after reset release

    logic [NUM_CHAN-1:0]   pend, gnt, wr_acc, rd_acc;
    logic                  gnt_vld;
    logic [IDX_W-1:0]      gnt_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  s0_vld, out_vld;
    logic [IDX_W-1:0]      s0_idx, out_idx;
    logic [DATA_WIDTH-1:0] s0_dat, out_dat;

    rr_arbiter #(.N(NUM_CHAN)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (pend),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        gnt_idx = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (gnt[c]) gnt_idx = IDX_W'(c);
        end
    end

    // Stage 0 is the grant cycle's array read; READ_LATENCY-1 registers follow, and the
    // response register itself is the last one.
    assign s0_vld = gnt_vld && (kind_q[gnt_idx] == KIND_LOAD);
    assign s0_idx = gnt_idx;
    assign s0_dat = mem[addr_q[gnt_idx]];

    generate
        if (READ_LATENCY == 1) begin : g_no_pipe
            assign out_vld = s0_vld;
            assign out_idx = s0_idx;
            assign out_dat = s0_dat;
        end else begin : g_pipe
            localparam int PD = READ_LATENCY - 1;
            logic [PD-1:0]         vld_q;
            logic [IDX_W-1:0]      idx_q [PD];
            logic [DATA_WIDTH-1:0] dat_q [PD];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < PD; i++) begin
                        idx_q[i] <= '0;
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= s0_vld;
                    idx_q[0] <= s0_idx;
                    dat_q[0] <= s0_dat;
                    for (int i = 1; i < PD; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign out_vld = vld_q[PD-1];
            assign out_idx = idx_q[PD-1];
            assign out_dat = dat_q[PD-1];
        end
    endgenerate

    // Array contents survive reset on purpose: stores that were granted stay visible.
    always_ff @(posedge clk) begin
        if (gnt_vld && (kind_q[gnt_idx] == KIND_STORE)) begin
            mem[addr_q[gnt_idx]] <= wdat_q[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
            for (int c = 0; c < NUM_CHAN; c++) state_q[c] <= IDLE;
        end else begin
            run_q <= 1'b1;
            for (int c = 0; c < NUM_CHAN; c++) state_q[c] <= state_d[c];
        end
    end

    // With a single-cycle read the data lands at the grant edge, so a load goes PEND -> RESP
    // and INFL only appears for READ_LATENCY > 1.
    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                IDLE: if (wr_acc[c] || rd_acc[c]) state_d[c] = PEND;
                PEND: if (gnt[c]) begin
                    if (kind_q[c] == KIND_STORE)                  state_d[c] = DONE;
                    else if (out_vld && out_idx == IDX_W'(c))     state_d[c] = RESP;
                    else                                          state_d[c] = INFL;
                end
                INFL: if (out_vld && out_idx == IDX_W'(c))        state_d[c] = RESP;
                RESP: if (bus.mem2read_resp_rdy[c])               state_d[c] = IDLE;
                DONE:                                             state_d[c] = IDLE;
                default:                                          state_d[c] = IDLE;
            endcase
        end
    end

    always_comb begin
        pend                       = '0;
        bus.mem2write_req_rdy      = '0;
        bus.mem2read_req_rdy       = '0;
        bus.mem2read_resp_data_val = '0;
        bus.mem2write_resp_val     = '0;
        bus.mem2read_resp_data     = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            pend[c]                       = (state_q[c] == PEND);
            bus.mem2write_req_rdy[c]      = run_q && (state_q[c] == IDLE);
            // A store presented in the same cycle takes the channel.
            bus.mem2read_req_rdy[c]       = run_q && (state_q[c] == IDLE) && !bus.mem2write_req_val[c];
            bus.mem2read_resp_data_val[c] = (state_q[c] == RESP);
            bus.mem2write_resp_val[c]     = (state_q[c] == DONE);
            bus.mem2read_resp_data[c]     = rdat_q[c];
        end
    end

    assign wr_acc = bus.mem2write_req_val     & bus.mem2write_req_rdy;
    assign rd_acc = bus.mem2read_req_addr_val & bus.mem2read_req_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                kind_q[c] <= KIND_LOAD;
                addr_q[c] <= '0;
                wdat_q[c] <= '0;
                rdat_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (wr_acc[c]) begin
                    kind_q[c] <= KIND_STORE;
                    addr_q[c] <= bus.mem2write_req_addr[c];
                    wdat_q[c] <= bus.mem2write_req_data[c];
                end else if (rd_acc[c]) begin
                    kind_q[c] <= KIND_LOAD;
                    addr_q[c] <= bus.mem2read_req_addr[c];
                end
            end
            if (out_vld) rdat_q[out_idx] <= out_dat;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: stores, loads, contention order, backpressure, reset.
// Latency: expectations assume READ_LATENCY = 1 (store ack at T+2, load data at T+2).
// Backpressure: resp_rdy held high except in the backpressure sequence.
module tb_data_mem_arbiter;
    import gpu_mem_pkg::*;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.NUM_CHAN(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_mem_arbiter #(
        .NUM_CHAN(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic store_ack(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.mem2write_req_addr[ch] = a;
        bus.mem2write_req_data[ch] = d;
        bus.mem2write_req_val[ch]  = 1'b1;
        @(posedge clk); #1;
        bus.mem2write_req_val[ch]  = 1'b0;
        @(negedge clk);
        chk($sformatf("st%0d_ack_t1", ch), bus.mem2write_resp_val[ch], 0);
        @(negedge clk);
        chk($sformatf("st%0d_ack_t2", ch), bus.mem2write_resp_val[ch], 1);
        @(negedge clk);
        chk($sformatf("st%0d_ack_t3", ch), bus.mem2write_resp_val[ch], 0);
        chk($sformatf("st%0d_wrdy_t3", ch), bus.mem2write_req_rdy[ch], 1);
    endtask

    task automatic load_check(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        @(negedge clk);
        bus.mem2read_req_addr[ch]     = a;
        bus.mem2read_req_addr_val[ch] = 1'b1;
        @(posedge clk); #1;
        bus.mem2read_req_addr_val[ch] = 1'b0;
        @(negedge clk);
        chk($sformatf("ld%0d_dv_t1", ch), bus.mem2read_resp_data_val[ch], 0);
        for (int i = 1; i < RL; i++) begin
            @(negedge clk);
            chk($sformatf("ld%0d_dv_early", ch), bus.mem2read_resp_data_val[ch], 0);
        end
        @(negedge clk);
        chk($sformatf("ld%0d_dv", ch), bus.mem2read_resp_data_val[ch], 1);
        chk($sformatf("ld%0d_data", ch), bus.mem2read_resp_data[ch], exp);
        @(negedge clk);
        chk($sformatf("ld%0d_dv_drop", ch), bus.mem2read_resp_data_val[ch], 0);
    endtask

    task automatic store_all(input logic [AW-1:0] base, input logic [DW-1:0] dbase);
        int pulses [NC];
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            bus.mem2write_req_addr[c] = base + AW'(c);
            bus.mem2write_req_data[c] = dbase + DW'(c);
            pulses[c] = 0;
        end
        bus.mem2write_req_val = '1;
        @(posedge clk); #1;
        bus.mem2write_req_val = '0;
        for (int cyc = 0; cyc < NC + 3; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) if (bus.mem2write_resp_val[c]) pulses[c]++;
        end
        for (int c = 0; c < NC; c++) chk($sformatf("stall_pulses%0d", c), pulses[c], 1);
    endtask

    // ep[c] is the grant position expected for channel c.
    task automatic contend(input string tag, input logic [AW-1:0] base,
                           input logic [DW-1:0] dbase, input int ep [NC]);
        int first [NC];
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            bus.mem2read_req_addr[c] = base + AW'(c);
            first[c] = -1;
        end
        bus.mem2read_req_addr_val = '1;
        @(posedge clk); #1;
        bus.mem2read_req_addr_val = '0;
        for (int cyc = 1; cyc <= NC + RL + 2; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (bus.mem2read_resp_data_val[c] && first[c] < 0) begin
                    first[c] = cyc;
                    chk($sformatf("%s_data%0d", tag, c), bus.mem2read_resp_data[c], dbase + DW'(c));
                end
            end
        end
        for (int c = 0; c < NC; c++)
            chk($sformatf("%s_cycle%0d", tag, c), first[c], 1 + RL + ep[c]);
    endtask

    int ep_a [NC];
    int ep_b [NC];
    int seen;
    int dvs;

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1);
    end

    initial begin
        bus.mem2read_req_addr      = '0;
        bus.mem2read_req_addr_val  = '0;
        bus.mem2read_resp_rdy      = '1;
        bus.mem2write_req_addr     = '0;
        bus.mem2write_req_data     = '0;
        bus.mem2write_req_val      = '0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rrdy", bus.mem2read_req_rdy, 0);
        chk("rst_wrdy", bus.mem2write_req_rdy, 0);
        chk("rst_dv", bus.mem2read_resp_data_val, 0);
        chk("rst_data", bus.mem2read_resp_data, 0);
        chk("rst_wresp", bus.mem2write_resp_val, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rrdy", bus.mem2read_req_rdy, 4'hF);
        chk("post_rst_wrdy", bus.mem2write_req_rdy, 4'hF);

        // Single store then load on another channel.
        store_ack(0, 8'h10, 16'hBEEF);
        load_check(1, 8'h10, 16'hBEEF);
        store_ack(2, 8'h05, 16'h1234);
        load_check(2, 8'h05, 16'h1234);

        // Preload contention addresses; a lone ch3 grant leaves the pointer at 0.
        store_all(8'h20, 16'hA000);
        store_ack(3, 8'h40, 16'h4444);
        ep_a = '{0, 1, 2, 3};
        contend("cont_a", 8'h20, 16'hA000, ep_a);
        // A lone ch1 grant moves the pointer to 2.
        load_check(1, 8'h40, 16'h4444);
`ifdef DATA_MEM_RR_ARB_EN
        ep_b = '{2, 3, 0, 1};
`else
        ep_b = '{0, 1, 2, 3};
`endif
        contend("cont_b", 8'h20, 16'hA000, ep_b);

        // Backpressure on ch0.
        @(negedge clk);
        bus.mem2read_resp_rdy[0]     = 1'b0;
        bus.mem2read_req_addr[0]     = 8'h10;
        bus.mem2read_req_addr_val[0] = 1'b1;
        @(posedge clk); #1;
        bus.mem2read_req_addr_val[0] = 1'b0;
        @(negedge clk);
        chk("bp_rrdy_t1", bus.mem2read_req_rdy[0], 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_dv_%0d", i), bus.mem2read_resp_data_val[0], 1);
            chk($sformatf("bp_data_%0d", i), bus.mem2read_resp_data[0], 16'hBEEF);
            chk($sformatf("bp_rrdy_%0d", i), bus.mem2read_req_rdy[0], 0);
        end
        bus.mem2read_resp_rdy[0] = 1'b1;
        @(negedge clk);
        chk("bp_dv_drop", bus.mem2read_resp_data_val[0], 0);
        chk("bp_rrdy_back", bus.mem2read_req_rdy[0], 1);

        // Simultaneous store and load on ch3: store wins, load waits for IDLE and sees the new value.
        @(negedge clk);
        bus.mem2write_req_addr[3]    = 8'h30;
        bus.mem2write_req_data[3]    = 16'h3333;
        bus.mem2write_req_val[3]     = 1'b1;
        bus.mem2read_req_addr[3]     = 8'h30;
        bus.mem2read_req_addr_val[3] = 1'b1;
        #1;
        chk("sim_rrdy", bus.mem2read_req_rdy[3], 0);
        chk("sim_wrdy", bus.mem2write_req_rdy[3], 1);
        @(posedge clk); #1;
        bus.mem2write_req_val[3] = 1'b0;
        seen = -1;
        for (int cyc = 1; cyc <= 6 && seen < 0; cyc++) begin
            @(negedge clk);
            if (bus.mem2read_req_rdy[3]) seen = cyc;
        end
        chk("sim_ld_accept_cycle", seen, 3);
        @(posedge clk); #1;
        bus.mem2read_req_addr_val[3] = 1'b0;
        @(negedge clk);
        chk("sim_ld_dv_t1", bus.mem2read_resp_data_val[3], 0);
        @(negedge clk);
        chk("sim_ld_dv", bus.mem2read_resp_data_val[3], 1);
        chk("sim_ld_data", bus.mem2read_resp_data[3], 16'h3333);

        // Reset while a ch1 load is outstanding.
        @(negedge clk);
        bus.mem2read_req_addr[1]     = 8'h10;
        bus.mem2read_req_addr_val[1] = 1'b1;
        @(posedge clk); #1;
        bus.mem2read_req_addr_val[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rrdy", bus.mem2read_req_rdy, 0);
        chk("mid_rst_wrdy", bus.mem2write_req_rdy, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_dv", bus.mem2read_resp_data_val, 0);
        rst_n = 1'b1;
        dvs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.mem2read_resp_data_val != '0) dvs++;
        end
        chk("mid_rst_no_resp", dvs, 0);
        chk("mid_rst_rrdy_back", bus.mem2read_req_rdy, 4'hF);
        load_check(1, 8'h10, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
